// File: rtl/mem_port_arbiter_pkg.sv
// Purpose: shared types and constants for the unified-memory port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_arb_pkg;

   // Arbiter FSM states
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_WAIT   = 2'd2,
      S_RESP   = 2'd3
   } arb_state_t;

   // Requester identities, also used as the owner output encoding
   localparam logic OWNER_CPU = 1'b0;
   localparam logic OWNER_DBG = 1'b1;

   // Tie-break policy when both requesters are active
   localparam logic PRIO_RR    = 1'b0;
   localparam logic PRIO_FIXED = 1'b1;

   // Latency counter width; MEM_LAT is limited to 1..7
   localparam int LAT_W = 3;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Purpose: bundles both requester ports and the memory-macro port of the arbiter.
// Latency: n/a (wires only).
// Backpressure: req is held stable by the requester until gnt; no stall on the memory side.
// Modports: master = arbiter side (drives gnt/rvalid/rdata and mem_*),
//           slave  = environment side (requesters plus memory macro).
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) ();

   // cpu requester
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_gnt;
   logic              cpu_rvalid;
   logic [DATA_W-1:0] cpu_rdata;

   // debug / program-loader requester
   logic              dbg_req;
   logic              dbg_we;
   logic [ADDR_W-1:0] dbg_addr;
   logic [DATA_W-1:0] dbg_wdata;
   logic              dbg_gnt;
   logic              dbg_rvalid;
   logic [DATA_W-1:0] dbg_rdata;

   // memory macro
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_gnt, cpu_rvalid, cpu_rdata,
      input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
      output dbg_gnt, dbg_rvalid, dbg_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport slave (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_gnt, cpu_rvalid, cpu_rdata,
      output dbg_req, dbg_we, dbg_addr, dbg_wdata,
      input  dbg_gnt, dbg_rvalid, dbg_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );

endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Purpose: combinational two-way picker (bit 0 = cpu, bit 1 = dbg).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the caller decides when the pick is used.
// Ports: req[1:0] requests, last = previous winner, mode = PRIO_RR/PRIO_FIXED,
//        grant_idx = winner (OWNER_CPU/OWNER_DBG), any = at least one request.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   input  logic       mode,
   output logic       grant_idx,
   output logic       any
);

   always_comb begin
      any       = |req;
      grant_idx = OWNER_CPU;
      if (req == 2'b11) begin
         // Contention: fixed mode favours cpu, round-robin favours whoever did not win last
         grant_idx = (mode == PRIO_FIXED) ? OWNER_CPU : ~last;
      end else if (req[1]) begin
         grant_idx = OWNER_DBG;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-port memory between the cpu and the debug/loader port.
// Latency: gnt + mem_en 1 cycle after the arbitration edge; rvalid A+1 (write), A+MEM_LAT+1 (read).
// Backpressure: one access in flight; a requester holds req until its gnt pulse.
// Ports: clk, reset (sync, active-low), bus (master modport: cpu_*, dbg_*, mem_*),
//        busy (state != IDLE), owner (0 = cpu, 1 = dbg).
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MEM_LAT   = 1,
   parameter int PRIO_MODE = 0
) (
   input  logic               clk,
   input  logic               reset,
   mem_port_arbiter_if.master bus,
   output logic               busy,
   output logic               owner
);

   if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_bad_lat
      $error("mem_port_arbiter: MEM_LAT must be in 1..7");
   end

   localparam logic             MODE     = (PRIO_MODE == 1) ? PRIO_FIXED : PRIO_RR;
   localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT - 1);

   arb_state_t        state;
   logic              last_owner;
   logic [LAT_W-1:0]  lat_cnt;
   logic [DATA_W-1:0] rdata_q;

   logic              win;
   logic              win_any;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   rr_arb2 u_pick (
      .req       ({bus.dbg_req, bus.cpu_req}),
      .last      (last_owner),
      .mode      (MODE),
      .grant_idx (win),
      .any       (win_any)
   );

   // Winner's request fields, captured at the arbitration edge
   always_comb begin
      sel_we    = bus.cpu_we;
      sel_addr  = bus.cpu_addr;
      sel_wdata = bus.cpu_wdata;
      if (win == OWNER_DBG) begin
         sel_we    = bus.dbg_we;
         sel_addr  = bus.dbg_addr;
         sel_wdata = bus.dbg_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state          <= S_IDLE;
         owner          <= OWNER_CPU;
         last_owner     <= OWNER_DBG;
         lat_cnt        <= '0;
         rdata_q        <= '0;
         bus.mem_en     <= 1'b0;
         bus.mem_we     <= 1'b0;
         bus.mem_addr   <= '0;
         bus.mem_wdata  <= '0;
         bus.cpu_gnt    <= 1'b0;
         bus.dbg_gnt    <= 1'b0;
         bus.cpu_rvalid <= 1'b0;
         bus.dbg_rvalid <= 1'b0;
      end else begin
         // Strobes are single-cycle pulses by default
         bus.mem_en     <= 1'b0;
         bus.mem_we     <= 1'b0;
         bus.cpu_gnt    <= 1'b0;
         bus.dbg_gnt    <= 1'b0;
         bus.cpu_rvalid <= 1'b0;
         bus.dbg_rvalid <= 1'b0;

         unique case (state)
            S_IDLE, S_RESP: begin
               if (win_any) begin
                  owner         <= win;
                  last_owner    <= win;
                  bus.mem_en    <= 1'b1;
                  bus.mem_we    <= sel_we;
                  bus.mem_addr  <= sel_addr;
                  bus.mem_wdata <= sel_wdata;
                  bus.cpu_gnt   <= (win == OWNER_CPU);
                  bus.dbg_gnt   <= (win == OWNER_DBG);
                  state         <= S_ACCESS;
               end else begin
                  state <= S_IDLE;
               end
            end

            S_ACCESS: begin
               // mem_we still holds the captured direction during ACCESS
               if (bus.mem_we) begin
                  bus.cpu_rvalid <= (owner == OWNER_CPU);
                  bus.dbg_rvalid <= (owner == OWNER_DBG);
                  state          <= S_RESP;
               end else begin
                  // MEM_LAT==1 spends a single WAIT cycle at count 0, the cycle
                  // in which the macro presents its data.
                  lat_cnt <= LAT_INIT;
                  state   <= S_WAIT;
               end
            end

            S_WAIT: begin
               if (lat_cnt == '0) begin
                  rdata_q        <= bus.mem_rdata;
                  bus.cpu_rvalid <= (owner == OWNER_CPU);
                  bus.dbg_rvalid <= (owner == OWNER_DBG);
                  state          <= S_RESP;
               end else begin
                  lat_cnt <= lat_cnt - LAT_W'(1);
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

   // Shared read-data register; only meaningful alongside the owner's rvalid
   assign bus.cpu_rdata = rdata_q;
   assign bus.dbg_rdata = rdata_q;
   assign busy          = (state != S_IDLE);

endmodule
